// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender for the decode path.
// Optional rotate-carry output is built only when IMM_ROT_CARRY_EN is defined.
module imm_extend_pipe #(
   parameter int WIDTH    = 32,
   parameter int INSTR_W  = 24,
   parameter int BR_SHIFT = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic [2:0]         imm_src,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   ext_imm,
   output logic               ext_err
`ifdef IMM_ROT_CARRY_EN
   ,
   input  logic               carry_in,
   output logic               rot_carry
`endif
);

   typedef enum logic [2:0] {
      FMT_ZX8  = 3'b000,
      FMT_ZX12 = 3'b001,
      FMT_BR   = 3'b010,
      FMT_ROT  = 3'b011,
      FMT_SX12 = 3'b100
   } fmt_e;

   if (WIDTH < INSTR_W + BR_SHIFT || WIDTH < 16 || INSTR_W < 12 ||
       BR_SHIFT < 0 || BR_SHIFT > 3) begin : g_bad_params
      $error("imm_extend_pipe: illegal WIDTH/INSTR_W/BR_SHIFT combination");
   end

   logic               s1_valid;
   logic [INSTR_W-1:0] s1_instr;
   logic [2:0]         s1_src;
   logic               s2_valid;
   logic               s1_adv;

   logic [WIDTH-1:0]   nxt_imm;
   logic               nxt_err;
   logic [WIDTH-1:0]   br_ext;
   logic [31:0]        rot_src;
   logic [4:0]         rot_amt;
   logic [31:0]        rot_val;

   // S2 can take new data when it is empty or its content leaves this cycle.
   assign s1_adv    = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s1_adv;
   assign out_valid = s2_valid;

   // Stage 1: capture the raw request.
   // NOTE: all state uses non-blocking assignments so every stage samples
   // the pre-edge value of its neighbour; blocking here would collapse stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_instr <= '0;
         s1_src   <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_instr <= instr;
            s1_src   <= imm_src;
         end
      end
   end

   assign br_ext  = WIDTH'($signed(s1_instr));
   assign rot_src = 32'(s1_instr[7:0]);
   assign rot_amt = {s1_instr[11:8], 1'b0};
   assign rot_val = 32'({rot_src, rot_src} >> rot_amt);

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      nxt_imm = '0;
      nxt_err = 1'b0;
      case (fmt_e'(s1_src))
         FMT_ZX8:  nxt_imm = WIDTH'(s1_instr[7:0]);
         FMT_ZX12: nxt_imm = WIDTH'(s1_instr[11:0]);
         FMT_BR:   nxt_imm = br_ext << BR_SHIFT;
         FMT_ROT:  nxt_imm = WIDTH'(rot_val);
         FMT_SX12: nxt_imm = WIDTH'($signed(s1_instr[11:0]));
         default:  nxt_err = 1'b1;
      endcase
   end

   // Stage 2: result register, frozen while the consumer stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         ext_imm  <= '0;
         ext_err  <= 1'b0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            ext_imm <= nxt_imm;
            ext_err <= nxt_err;
         end
      end
   end

`ifdef IMM_ROT_CARRY_EN
   logic s1_carry;
   logic nxt_carry;

   // A zero rotate leaves the carry untouched, mirroring a barrel shifter.
   assign nxt_carry = (fmt_e'(s1_src) == FMT_ROT && rot_amt != 5'd0) ?
                      rot_val[31] : s1_carry;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_carry <= 1'b0;
      end else if (in_ready && in_valid) begin
         s1_carry <= carry_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rot_carry <= 1'b0;
      end else if (s1_adv && s1_valid) begin
         rot_carry <= nxt_carry;
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomised self-checking bench for imm_extend_pipe with a queue-based reference model.
// Define IMM_ROT_CARRY_EN for both files to exercise the carry port.
module tb_imm_extend_pipe;

   localparam int W  = 32;
   localparam int IW = 24;
   localparam int BR = 2;

   typedef struct {
      logic [31:0] imm;
      logic        err;
      logic        carry;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] instr = '0;
   logic [2:0]    imm_src = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  ext_imm;
   logic          ext_err;
   logic          carry_in = 1'b0;
`ifdef IMM_ROT_CARRY_EN
   logic          rot_carry;
`endif

   imm_extend_pipe #(.WIDTH(W), .INSTR_W(IW), .BR_SHIFT(BR)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .imm_src   (imm_src),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ext_imm   (ext_imm),
      .ext_err   (ext_err)
`ifdef IMM_ROT_CARRY_EN
      ,
      .carry_in  (carry_in),
      .rot_carry (rot_carry)
`endif
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_out = 0;
   int          ready_mode = 1;   // 0: stall, 1: always ready, 2: random
   exp_t        expq[$];
   exp_t        mon_e;
   logic [31:0] last_imm = '0;
   logic        last_err = 1'b0;
   logic        last_carry = 1'b0;
   logic        held_v = 1'b0;
   logic [31:0] held_imm = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: formats computed with plain integer arithmetic.
   function automatic exp_t model(input logic [2:0] s, input logic [23:0] i, input logic c);
      exp_t   m;
      longint v;
      int     a;
      m.imm   = '0;
      m.err   = 1'b0;
      m.carry = c;
      v       = 0;
      case (s)
         3'd0: v = longint'(i) % 256;
         3'd1: v = longint'(i) % 4096;
         3'd2: begin
            v = longint'(i);
            if (v >= 64'sd8388608) v = v - 64'sd16777216;
            v = v * (64'sd1 << BR);
         end
         3'd3: begin
            v = longint'(i) % 256;
            a = 2 * ((int'(i) / 256) % 16);
            for (int k = 0; k < a; k++) v = (v / 2) + ((v % 2) << 31);
            if (a != 0) m.carry = v[31];
         end
         3'd4: begin
            v = longint'(i) % 4096;
            if (v >= 2048) v = v - 4096;
         end
         default: m.err = 1'b1;
      endcase
      m.imm = v[31:0];
      return m;
   endfunction

   // Consumer-side ready driver, updated 2 time units after each rising edge.
   initial begin
      forever begin
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         @(posedge clk);
         #2;
      end
   end

   // Scoreboard and stall-stability monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_imm", 64'(ext_imm), 64'(held_imm));
         end
         if (out_valid && out_ready) begin
            check("out_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
               mon_e = expq.pop_front();
               check("ext_imm", 64'(ext_imm), 64'(mon_e.imm));
               check("ext_err", 64'(ext_err), 64'(mon_e.err));
`ifdef IMM_ROT_CARRY_EN
               check("rot_carry", 64'(rot_carry), 64'(mon_e.carry));
               last_carry = rot_carry;
`endif
            end
            last_imm = ext_imm;
            last_err = ext_err;
            n_out++;
         end
         if (in_valid && in_ready) expq.push_back(model(imm_src, instr, carry_in));
         held_v   = out_valid && !out_ready;
         held_imm = ext_imm;
      end
   end

   task automatic send(input logic [2:0] s, input logic [23:0] i, input logic c);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      imm_src  = s;
      instr    = i;
      carry_in = c;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) check("send_accept", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      ready_mode = 1;
      for (int k = 0; k < 100 && expq.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      check("drain_empty", 64'(expq.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string tag, input logic [2:0] s, input logic [23:0] i,
                           input logic c, input logic [31:0] e_imm, input logic e_err,
                           input logic e_carry);
      send(s, i, c);
      drain();
      check({tag, "_imm"}, 64'(last_imm), 64'(e_imm));
      check({tag, "_err"}, 64'(last_err), 64'(e_err));
`ifdef IMM_ROT_CARRY_EN
      check({tag, "_carry"}, 64'(last_carry), 64'(e_carry));
`else
      if (e_carry !== last_carry) ;
`endif
   endtask

   initial begin
      int          base;
      logic [31:0] exp_a;

      // Reset state
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_ext_imm", 64'(ext_imm), 64'd0);
      check("rst_ext_err", 64'(ext_err), 64'd0);
      #11 reset_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid_rel", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      // Format corner cases
      directed("br_neg",   3'b010, 24'hFFFFFE, 1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0);
      directed("rot8",     3'b011, 24'h0004FF, 1'b0, 32'hFF00_0000, 1'b0, 1'b1);
      directed("rot0",     3'b011, 24'h0000FF, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
      directed("rot0_c1",  3'b011, 24'h0000FF, 1'b1, 32'h0000_00FF, 1'b0, 1'b1);
      directed("sx12",     3'b100, 24'h000800, 1'b0, 32'hFFFF_F800, 1'b0, 1'b0);
      directed("zx12",     3'b001, 24'h000800, 1'b0, 32'h0000_0800, 1'b0, 1'b0);
      directed("zx8",      3'b000, 24'h000ABC, 1'b0, 32'h0000_00BC, 1'b0, 1'b0);
      directed("undef",    3'b111, 24'h123456, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
      directed("after_ud", 3'b000, 24'h123456, 1'b0, 32'h0000_0056, 1'b0, 1'b0);
      directed("br_pos",   3'b010, 24'h7FFFFF, 1'b0, 32'h01FF_FFFC, 1'b0, 1'b0);

      // Back-pressure: capacity of two, stable head, in-order release
      ready_mode = 0;
      @(posedge clk);
      #1;
      base  = n_out;
      exp_a = 32'h11;
      send(3'b000, 24'h000011, 1'b0);
      send(3'b000, 24'h000022, 1'b0);
      in_valid = 1'b1;
      imm_src  = 3'b000;
      instr    = 24'h000033;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_head_imm", 64'(ext_imm), 64'(exp_a));
         @(posedge clk);
         #1;
      end
      ready_mode = 1;
      @(negedge clk);
      check("bp_rel_ready", 64'(in_ready), 64'd1);
      check("bp_rel_valid0", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_rel_valid1", 64'(out_valid), 64'd1);
      @(negedge clk);
      check("bp_rel_valid2", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      check("bp_delivered", 64'(n_out - base), 64'd3);
      drain();

      // Reset with two entries in flight
      ready_mode = 0;
      @(posedge clk);
      #1;
      send(3'b001, 24'h000ABC, 1'b1);
      send(3'b100, 24'h000FFF, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ext_imm", 64'(ext_imm), 64'd0);
      check("mid_rst_ext_err", 64'(ext_err), 64'd0);
      expq.delete();
      #9 reset_n = 1'b1;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      ready_mode = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("mid_rst_no_stale", 64'(out_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // Randomised traffic with random back-pressure and idle gaps
      ready_mode = 2;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(3'($urandom_range(0, 7)), 24'($urandom), 1'($urandom));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Pipelined, parametrised immediate-extension unit for the decode path. It accepts an instruction immediate field plus a format select over a valid/ready handshake and produces a WIDTH-bit extended immediate two cycles later.
- Generalises the fixed 32-bit combinational extender: adds signed-12 and rotated-8 formats, flags undefined selects, and supports back-pressure.
- Sits between instruction decode and the operand-select mux of the execute stage.

Parameters:
WIDTH, 32, output immediate width; must be >= INSTR_W+BR_SHIFT and >= 16.
INSTR_W, 24, width of incoming immediate field; must be >= 12.
BR_SHIFT, 2, left shift applied to branch offsets; range 0..3.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request this cycle.
instr  input  INSTR_W  instruction immediate field.
imm_src  input  3  format select.
out_valid  output  1  ext_imm/ext_err valid.
out_ready  input  1  consumer accepts result.
ext_imm  output  WIDTH  extended immediate.
ext_err  output  1  imm_src was undefined.

Behaviour:
- Reset: one clock; asynchronous active-low reset. While reset_n=0:
  - both stage valid bits are cleared;
  - out_valid=0, ext_imm=0, ext_err=0, in_ready=1 on the first cycle after release.
  - Reset mid-operation discards all in-flight requests. No partial output appears.
- Pipeline: S1 registers instr/imm_src; S2 registers the computed ext_imm/ext_err.
  - Latency: accept at edge N -> out_valid=1 after edge N+1 (2 register stages). Full throughput of 1/cycle when out_ready=1.
- Handshake: a transfer occurs when valid&ready at a rising edge.
  - in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready.
  - S2 holds ext_imm/ext_err stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
  - Ordering is strictly preserved.
  - Capacity is 2 entries. With out_ready=0 held, exactly 2 requests are accepted, then in_ready=0.
- Formats (computed from S1 contents):
  - 000: zero-extend instr[7:0].
  - 001: zero-extend instr[11:0].
  - 010: sign-extend instr[INSTR_W-1:0] to WIDTH, then shift left by BR_SHIFT (low bits 0). The shift is applied after extension, so no bits are lost.
  - 011: rotated: zero-extend instr[7:0] to 32 bits, rotate right by 2*instr[11:8] within the low 32 bits, then zero-extend to WIDTH.
  - 100: sign-extend instr[11:0].
  - 101, 110, 111: ext_imm=0, ext_err=1.
  - ext_err=0 for all defined formats.
- Simultaneous events:
  - When S2 drains and S1 advances and a new input is accepted in the same cycle, all three occur; no bubble.
  - in_valid while in_ready=0: no transfer. The source must hold its data (not checked).

Optional Feature:
IMM_ROT_CARRY_EN: adds two ports:
- carry_in, input, 1 bit;
- rot_carry, output, 1 bit.

rot_carry is pipelined alongside ext_imm:
- format 011 with rotate amount != 0: rot_carry = bit 31 of the rotated value;
- format 011 with rotate amount 0, and all other formats: rot_carry = carry_in as captured with the request;
- reset value 0.

Without the macro these ports do not exist and no carry logic is built.

Test Plan:
- Format 010, instr=24'hFFFFFE, out_ready=1 -> two cycles later ext_imm=32'hFFFFFFF8, ext_err=0.
- Format 011, instr=24'h0004FF -> ext_imm=32'hFF000000. With IMM_ROT_CARRY_EN, carry_in=0 -> rot_carry=1. Same with instr=24'h0000FF -> ext_imm=32'h000000FF, rot_carry=0.
- Format 100, instr=24'h000800 -> ext_imm=32'hFFFFF800. Format 001, same instr -> 32'h00000800. Format 000, instr=24'h000ABC -> 32'h000000BC.
- Format 111, any instr -> ext_imm=0, ext_err=1. The following format-000 request gives ext_err=0.
- Back-pressure sequence:
  - Stimulus: out_ready=0; offer A, B, C back-to-back.
  - Response: A and B accepted, in_ready=0 while C is held; out_valid=1 with A stable.
  - Then out_ready=1: A, B, C are delivered on consecutive cycles in order.
- Reset mid-operation:
  - Stimulus: reset_n pulsed low while 2 entries are in flight.
  - Response: out_valid=0 and ext_imm=0 immediately (asynchronously). After release, the old data is never emitted and in_ready=1.
